// File: rtl/sram_mbist_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_mbist_ctrl_pkg
// Shared definitions for the March C- BIST controller: FSM state encoding,
// March element count, background data constants and the per-element
// direction/operation table used by the sequencer.
// ---------------------------------------------------------------------------
package sram_mbist_ctrl_pkg;

  // Core address width seen by sram_core (upper bits unused by BIST)
  localparam int CORE_AW = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_t;

  localparam int         NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

  localparam logic [7:0] DATA0 = 8'h00;
  localparam logic [7:0] DATA1 = 8'hFF;

  // One row of the March C- table. rd_one/wr_one select DATA1 over DATA0.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic has_wr;
    logic rd_one;
    logic wr_one;
  } elem_info_t;

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0)
  function automatic elem_info_t elem_info(input logic [2:0] elem);
    elem_info_t info;
    case (elem)
      3'd0:    info = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      3'd1:    info = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      3'd2:    info = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      3'd3:    info = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      3'd4:    info = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      3'd5:    info = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      default: info = '0;
    endcase
    return info;
  endfunction

  function automatic logic [7:0] lane_data(input logic one);
    return one ? DATA1 : DATA0;
  endfunction

endpackage

// File: rtl/sram_mbist_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_mbist_ctrl_if
// Core-side SRAM bus between the BIST controller and sram_core.
//   bank0_csn/bank1_csn : per-lane chip selects (active low)
//   sram_we             : 1 = write
//   sram_wdata          : 32-bit write data (one byte per lane)
//   sram_addr           : core address
//   sram_q0..sram_q7    : read data from the 8 macros, valid 1 clk after a read
// master = controller side, slave = core side.
// ---------------------------------------------------------------------------
interface sram_mbist_ctrl_if;
  import sram_mbist_ctrl_pkg::*;

  logic [3:0]         bank0_csn;
  logic [3:0]         bank1_csn;
  logic               sram_we;
  logic [31:0]        sram_wdata;
  logic [CORE_AW-1:0] sram_addr;
  logic [7:0]         sram_q0, sram_q1, sram_q2, sram_q3;
  logic [7:0]         sram_q4, sram_q5, sram_q6, sram_q7;

  modport master (
    output bank0_csn, bank1_csn, sram_we, sram_wdata, sram_addr,
    input  sram_q0, sram_q1, sram_q2, sram_q3,
           sram_q4, sram_q5, sram_q6, sram_q7
  );

  modport slave (
    input  bank0_csn, bank1_csn, sram_we, sram_wdata, sram_addr,
    output sram_q0, sram_q1, sram_q2, sram_q3,
           sram_q4, sram_q5, sram_q6, sram_q7
  );
endinterface

// File: rtl/sram_mbist_ctrl_seq.sv
// ---------------------------------------------------------------------------
// sram_mbist_ctrl_seq
// March C- sequencer: element, address and op-phase counters.
//   clk, rst   : clock, synchronous active-high reset
//   init       : reload counters to the first operation of M0
//   en         : advance one operation
//   elem       : current March element (0..5)
//   addr       : current macro address
//   is_write   : current operation is a write (else a read)
//   data       : write data, or expected read data, for the current op
//   last       : current op is the final read of M5
// ---------------------------------------------------------------------------
module sram_mbist_ctrl_seq
  import sram_mbist_ctrl_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          en,
  output logic [2:0]    elem,
  output logic [AW-1:0] addr,
  output logic          is_write,
  output logic [7:0]    data,
  output logic          last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  elem_info_t    info;
  elem_info_t    next_info;
  logic          phase;
  logic          op_done;
  logic          elem_end;
  logic [AW-1:0] end_addr;

  assign info      = elem_info(elem);
  assign next_info = elem_info(elem + 3'd1);

  // In two-op elements phase 0 is the read and phase 1 the write at the same address
  assign is_write = info.has_wr && (!info.has_rd || phase);
  assign op_done  = !(info.has_rd && info.has_wr) || phase;
  assign end_addr = info.down ? '0 : LAST_ADDR;
  assign elem_end = op_done && (addr == end_addr);
  assign last     = elem_end && (elem == LAST_ELEM);
  assign data     = is_write ? lane_data(info.wr_one) : lane_data(info.rd_one);

  // Counters hold on the final op; the controller leaves RUN on that cycle
  always_ff @(posedge clk) begin
    if (rst || init) begin
      elem  <= '0;
      addr  <= '0;
      phase <= 1'b0;
    end else if (en && !last) begin
      if (!op_done) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        if (elem_end) begin
          elem <= elem + 3'd1;
          addr <= next_info.down ? LAST_ADDR : '0;
        end else begin
          addr <= info.down ? addr - 1'b1 : addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_mbist_ctrl.sv
// ---------------------------------------------------------------------------
// sram_mbist_ctrl
// March C- BIST controller for the 2-bank x 4-lane SRAM core. Passes the
// functional bus through when not testing; while running it owns the core,
// tests all 8 macros in parallel and records per-lane failures plus the
// address/element of the first mismatch.
//   clk, rst           : clock, synchronous active-high reset
//   bist_start         : 1-cycle start pulse (ignored while busy)
//   f_*                : functional-side core controls
//   core               : core-side SRAM bus (master modport)
//   bist_busy          : run in progress
//   bist_done          : sticky end-of-run flag
//   bist_fail          : sticky per-lane mismatch flags
//   fail_addr/elem     : address and March element of the first mismatch
// ---------------------------------------------------------------------------
module sram_mbist_ctrl
  import sram_mbist_ctrl_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bist_start,
  input  logic [3:0]         f_bank0_csn,
  input  logic [3:0]         f_bank1_csn,
  input  logic               f_we,
  input  logic [31:0]        f_wdata,
  input  logic [CORE_AW-1:0] f_addr,
  sram_mbist_ctrl_if.master  core,
  output logic               bist_busy,
  output logic               bist_done,
  output logic [7:0]         bist_fail,
  output logic [AW-1:0]      fail_addr,
  output logic [2:0]         fail_elem
);

  bist_state_t   state;
  logic          start_ok;
  logic          run_en;
  logic [2:0]    seq_elem;
  logic [AW-1:0] seq_addr;
  logic          seq_write;
  logic [7:0]    seq_data;
  logic          seq_last;

  logic          rd_valid_q;
  logic [7:0]    exp_q;
  logic [AW-1:0] rd_addr_q;
  logic [2:0]    rd_elem_q;
  logic [7:0]    lane_q [8];
  logic [7:0]    mismatch;

  assign start_ok = bist_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign run_en   = (state == ST_RUN);

  sram_mbist_ctrl_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .init     (start_ok),
    .en       (run_en),
    .elem     (seq_elem),
    .addr     (seq_addr),
    .is_write (seq_write),
    .data     (seq_data),
    .last     (seq_last)
  );

  // Core gets the March operation only in RUN; otherwise the functional path
  always_comb begin
    core.bank0_csn  = f_bank0_csn;
    core.bank1_csn  = f_bank1_csn;
    core.sram_we    = f_we;
    core.sram_wdata = f_wdata;
    core.sram_addr  = f_addr;
    if (run_en) begin
      core.bank0_csn  = 4'b0000;
      core.bank1_csn  = 4'b0000;
      core.sram_we    = seq_write;
      core.sram_wdata = {4{seq_data}};
      core.sram_addr  = {{(CORE_AW - AW){1'b0}}, seq_addr};
    end
  end

  assign lane_q[0] = core.sram_q0;
  assign lane_q[1] = core.sram_q1;
  assign lane_q[2] = core.sram_q2;
  assign lane_q[3] = core.sram_q3;
  assign lane_q[4] = core.sram_q4;
  assign lane_q[5] = core.sram_q5;
  assign lane_q[6] = core.sram_q6;
  assign lane_q[7] = core.sram_q7;

  // Read data arrives one cycle after the read, so compare against the delayed expectation
  always_comb begin
    mismatch = '0;
    for (int n = 0; n < 8; n++) begin
      mismatch[n] = rd_valid_q && (lane_q[n] != exp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bist_busy  <= 1'b0;
      bist_done  <= 1'b0;
      bist_fail  <= '0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      rd_valid_q <= 1'b0;
      exp_q      <= '0;
      rd_addr_q  <= '0;
      rd_elem_q  <= '0;
    end else begin
      rd_valid_q <= run_en && !seq_write;
      exp_q      <= seq_data;
      rd_addr_q  <= seq_addr;
      rd_elem_q  <= seq_elem;

      // Only the first failing read records its location; later ones just OR in
      if (|mismatch) begin
        if (bist_fail == 8'h00) begin
          fail_addr <= rd_addr_q;
          fail_elem <= rd_elem_q;
        end
        bist_fail <= bist_fail | mismatch;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (bist_start) begin
            state     <= ST_RUN;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
        end
        ST_RUN: begin
          if (seq_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state     <= ST_DONE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
